// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one Uart transmitter
// between N byte-stream requesters, with a stall watchdog and one output byte register.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic           CLK,
  input  logic           RST_,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] DATA,
  input  logic [N-1:0]   LAST,
  output logic [N-1:0]   ACK,
  output logic [N-1:0]   GNT,
  output logic [W-1:0]   OUT,
  output logic           OE,
  input  logic           RDY,
  output logic           ABORT
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_d;
  logic [PW-1:0]  p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           abort_d;

  logic [PW-1:0]  g;
  logic [PW-1:0]  g_next;
  logic           g_req, g_last;
  logic [W-1:0]   g_data;
  logic           space, load;

  // First requesting lane at or after start, wrapping around.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] req,
                                            input logic [PW-1:0] start);
    logic [PW-1:0] pick;
    pick = start;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(start) + k) % N]) pick = PW'((int'(start) + k) % N);
    end
    return pick;
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    g = '0;
    for (int i = 0; i < N; i++) begin
      if (GNT[i]) g = PW'(i);
    end
  end

  assign g_next = PW'((int'(g) + 1) % N);
  assign g_req  = REQ[g];
  assign g_last = LAST[g];
  assign g_data = DATA[int'(g)*W +: W];

  assign space = !OE || RDY;
  assign load  = (state_q == LOCK) && g_req && space;
  assign ACK   = load ? GNT : '0;

  always_comb begin
    state_d = state_q;
    gnt_d   = GNT;
    p_d     = p_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          state_d = LOCK;
          gnt_d   = '0;
          gnt_d[rr_pick(REQ, p_q)] = 1'b1;
          cnt_d   = '0;
        end
      end
      LOCK: begin
        if (load) begin
          cnt_d = '0;
          if (g_last) begin
            state_d = IDLE;
            gnt_d   = '0;
            p_d     = g_next;
          end
        end else if (!g_req) begin
          // Only an owner that has nothing to offer is stalling; RDY back-pressure is not.
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            gnt_d   = '0;
            p_d     = g_next;
            cnt_d   = '0;
            abort_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state_q <= IDLE;
      GNT     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      ABORT   <= 1'b0;
    end else begin
      state_q <= state_d;
      GNT     <= gnt_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      ABORT   <= abort_d;
    end
  end

  // The output byte register drains independently of the grant state.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      OUT <= '0;
      OE  <= 1'b0;
    end else if (load) begin
      OUT <= g_data;
      OE  <= 1'b1;
    end else if (RDY) begin
      OE  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a per-cycle vector table plus
// hand-written sequences for rotation, pre-emption, watchdog and async reset.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 8;

  logic           CLK = 1'b0;
  logic           RST_;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] DATA;
  logic [N-1:0]   LAST;
  logic [N-1:0]   ACK;
  logic [N-1:0]   GNT;
  logic [W-1:0]   OUT;
  logic           OE;
  logic           RDY;
  logic           ABORT;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_(RST_), .REQ(REQ), .DATA(DATA), .LAST(LAST),
    .ACK(ACK), .GNT(GNT), .OUT(OUT), .OE(OE), .RDY(RDY), .ABORT(ABORT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rdy;
    logic [3:0] req;
    int         lane;
    logic [7:0] byt;
    logic       last;
    logic [3:0] ack;
    logic [3:0] gnt;
    logic [7:0] out;
    logic       oe;
    logic       abort;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [N*W-1:0] put(input int lane, input logic [7:0] b);
    logic [N*W-1:0] v;
    v = '0;
    v[lane*W +: W] = b;
    return v;
  endfunction

  task automatic do_reset();
    RST_ = 1'b0;
    REQ  = '0;
    LAST = '0;
    DATA = '0;
    RDY  = 1'b1;
    tick();
    tick();
    #3 RST_ = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    // Reset state with all requesters asking.
    RST_ = 1'b0;
    REQ  = 4'b1111;
    LAST = '0;
    DATA = '0;
    RDY  = 1'b1;
    tick();
    tick();
    check("rst_gnt", GNT, 0);
    check("rst_ack", ACK, 0);
    check("rst_oe", OE, 0);
    check("rst_out", OUT, 0);
    check("rst_abort", ABORT, 0);
    REQ = '0;
    #3 RST_ = 1'b1;
    tick();

    // Lane 0 sends "Hi!", then lane 1 sends 41,42,43 with a 5-cycle RDY stall.
    vt.push_back(vec_t'{1, 4'b0001, 0, 8'h48, 0, 4'b0000, 4'b0000, 8'h00, 0, 0});
    vt.push_back(vec_t'{1, 4'b0001, 0, 8'h48, 0, 4'b0001, 4'b0001, 8'h00, 0, 0});
    vt.push_back(vec_t'{1, 4'b0001, 0, 8'h69, 0, 4'b0001, 4'b0001, 8'h48, 1, 0});
    vt.push_back(vec_t'{1, 4'b0001, 0, 8'h21, 1, 4'b0001, 4'b0001, 8'h69, 1, 0});
    vt.push_back(vec_t'{1, 4'b0000, 0, 8'h00, 0, 4'b0000, 4'b0000, 8'h21, 1, 0});
    vt.push_back(vec_t'{1, 4'b0000, 0, 8'h00, 0, 4'b0000, 4'b0000, 8'h21, 0, 0});
    vt.push_back(vec_t'{1, 4'b0010, 1, 8'h41, 0, 4'b0000, 4'b0000, 8'h21, 0, 0});
    vt.push_back(vec_t'{1, 4'b0010, 1, 8'h41, 0, 4'b0010, 4'b0010, 8'h21, 0, 0});
    for (int s = 0; s < 5; s++)
      vt.push_back(vec_t'{0, 4'b0010, 1, 8'h42, 0, 4'b0000, 4'b0010, 8'h41, 1, 0});
    vt.push_back(vec_t'{1, 4'b0010, 1, 8'h42, 0, 4'b0010, 4'b0010, 8'h41, 1, 0});
    vt.push_back(vec_t'{1, 4'b0010, 1, 8'h43, 1, 4'b0010, 4'b0010, 8'h42, 1, 0});
    vt.push_back(vec_t'{1, 4'b0000, 1, 8'h00, 0, 4'b0000, 4'b0000, 8'h43, 1, 0});
    vt.push_back(vec_t'{1, 4'b0000, 1, 8'h00, 0, 4'b0000, 4'b0000, 8'h43, 0, 0});

    foreach (vt[i]) begin
      RDY  = vt[i].rdy;
      REQ  = vt[i].req;
      DATA = put(vt[i].lane, vt[i].byt);
      LAST = vt[i].last ? (4'b0001 << vt[i].lane) : 4'b0000;
      #1;
      check($sformatf("vec%0d_ack", i), ACK, vt[i].ack);
      check($sformatf("vec%0d_gnt", i), GNT, vt[i].gnt);
      check($sformatf("vec%0d_oe", i), OE, vt[i].oe);
      if (vt[i].oe) check($sformatf("vec%0d_out", i), OUT, vt[i].out);
      check($sformatf("vec%0d_abort", i), ABORT, vt[i].abort);
      tick();
    end

    // Rotation: all lanes request single-byte messages.
    do_reset();
    REQ  = 4'b1111;
    LAST = 4'b1111;
    DATA = put(0, 8'hA0) | put(1, 8'hA1) | put(2, 8'hA2) | put(3, 8'hA3);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rot%0d_gnt", k), GNT, 4'b0001 << (k % 4));
      check($sformatf("rot%0d_ack", k), ACK, 4'b0001 << (k % 4));
      tick();
      check($sformatf("rot%0d_release", k), GNT, 0);
      check($sformatf("rot%0d_noack", k), ACK, 0);
      check($sformatf("rot%0d_out", k), OUT, 8'hA0 + (k % 4));
      check($sformatf("rot%0d_oe", k), OE, 1);
    end
    REQ = '0;
    tick();
    check("rot_idle_gnt", GNT, 0);

    // Lane 2 owns a 4-byte message; lane 0 must wait for its LAST.
    REQ  = 4'b0100;
    LAST = '0;
    DATA = put(2, 8'hC1);
    tick();
    check("pre_gnt", GNT, 4'b0100);
    check("pre_ack1", ACK, 4'b0100);
    tick();
    REQ  = 4'b0101;
    LAST = 4'b0001;
    DATA = put(2, 8'hC2) | put(0, 8'hD0);
    #1;
    check("pre_ack2", ACK, 4'b0100);
    check("pre_out1", OUT, 8'hC1);
    tick();
    DATA = put(2, 8'hC3) | put(0, 8'hD0);
    #1;
    check("pre_ack3", ACK, 4'b0100);
    check("pre_out2", OUT, 8'hC2);
    tick();
    DATA = put(2, 8'hC4) | put(0, 8'hD0);
    LAST = 4'b0101;
    #1;
    check("pre_ack4", ACK, 4'b0100);
    check("pre_out3", OUT, 8'hC3);
    tick();
    REQ  = 4'b0001;
    LAST = 4'b0001;
    #1;
    check("pre_release", GNT, 0);
    check("pre_idle_ack", ACK, 0);
    check("pre_out4", OUT, 8'hC4);
    tick();
    check("pre_lane0_gnt", GNT, 4'b0001);
    check("pre_lane0_ack", ACK, 4'b0001);
    tick();
    REQ = '0;
    #1;
    check("pre_lane0_done", GNT, 0);
    check("pre_lane0_out", OUT, 8'hD0);
    tick();

    // Watchdog: lane 3 stalls after one byte while the Uart is also stalled.
    REQ  = 4'b1000;
    LAST = '0;
    DATA = put(3, 8'hE1);
    RDY  = 1'b1;
    tick();
    REQ  = 4'b1010;
    LAST = 4'b0010;
    DATA = put(3, 8'hE1) | put(1, 8'hF1);
    #1;
    check("wd_gnt", GNT, 4'b1000);
    check("wd_ack", ACK, 4'b1000);
    tick();
    REQ = 4'b0010;
    RDY = 1'b0;
    #1;
    check("wd_out", OUT, 8'hE1);
    check("wd_nonowner_ack", ACK, 0);
    check("wd_abort_early", ABORT, 0);
    for (int k = 3; k <= 9; k++) begin
      tick();
      check($sformatf("wd_c%0d_abort", k), ABORT, 0);
      check($sformatf("wd_c%0d_gnt", k), GNT, 4'b1000);
      check($sformatf("wd_c%0d_ack", k), ACK, 0);
    end
    tick();
    check("wd_abort", ABORT, 1);
    check("wd_abort_gnt", GNT, 0);
    check("wd_held_oe", OE, 1);
    check("wd_held_out", OUT, 8'hE1);
    tick();
    check("wd_abort_pulse", ABORT, 0);
    check("wd_next_gnt", GNT, 4'b0010);
    RDY = 1'b1;
    #1;
    check("wd_next_ack", ACK, 4'b0010);
    check("wd_drain_out", OUT, 8'hE1);
    tick();
    REQ = '0;
    #1;
    check("wd_next_out", OUT, 8'hF1);
    check("wd_next_release", GNT, 0);
    tick();
    check("wd_drained", OE, 0);

    // Asynchronous reset while lane 2 owns the grant and a byte is buffered.
    REQ  = 4'b0100;
    LAST = '0;
    DATA = put(2, 8'h77);
    tick();
    DATA = put(2, 8'h78);
    tick();
    check("arst_pre_oe", OE, 1);
    check("arst_pre_gnt", GNT, 4'b0100);
    #1 RST_ = 1'b0;
    #1;
    check("arst_oe", OE, 0);
    check("arst_gnt", GNT, 0);
    check("arst_ack", ACK, 0);
    check("arst_out", OUT, 0);
    REQ  = 4'b1111;
    LAST = 4'b1111;
    DATA = put(0, 8'hB0) | put(1, 8'hB1) | put(2, 8'hB2) | put(3, 8'hB3);
    #3 RST_ = 1'b1;
    tick();
    check("arst_first_gnt", GNT, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single Uart transmitter between N byte-stream requesters, such as the boot-text streamer, a debug/status source and the terminal echo. Arbitration is round-robin at message granularity. A requester holds the grant until its byte flagged LAST is taken, or until a stall watchdog revokes it. The block sits between the requesters and the Uart IN/OE/RDY port and holds one output byte register that drives the Uart.

Parameters:
N, 4, number of requesters (1..8)
W, 8, byte width
TIMEOUT, 1024, consecutive owner-stall cycles before forced release (>=2)

Ports:
CLK  input  1  system clock, all state on rising edge
RST_  input  1  reset, asynchronous, active-low
REQ  input  N  lane i has a valid byte on DATA lane i
DATA  input  N*W  lane i at [i*W +: W]
LAST  input  N  lane i's current byte ends its message
ACK  output  N  combinational one-hot strobe: lane i's byte taken this cycle
GNT  output  N  registered one-hot current owner; 0 when idle
OUT  output  W  byte to Uart IN
OE  output  1  OUT valid, to Uart OE
RDY  input  1  Uart ready; byte transfers on a cycle with OE && RDY
ABORT  output  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (RST_ low, immediate, no clock needed): GNT=0, ACK=0, OE=0, OUT=0, ABORT=0, rr pointer p=0, stall counter=0, state IDLE. A buffered byte is discarded.
- States: IDLE, LOCK. g = index of the set GNT bit.
- IDLE:
  - If any REQ is high, select the first set bit scanning circularly from p.
  - Next edge: GNT=onehot(sel), state LOCK.
  - Arbitration latency is 1 cycle. ACK is never asserted in IDLE.
- Output buffer (independent of state):
  - space = !OE || RDY.
  - load = LOCK && REQ[g] && space.
  - On load: ACK[g]=1 that cycle; next edge OUT<=DATA[g], OE<=1.
  - On OE && RDY && !load: OE<=0 next edge.
  - OUT must stay stable while OE && !RDY.
  - Throughput is 1 byte/cycle with RDY held high.
- LOCK release on message end: a load with LAST[g]=1 sets, on the next edge, GNT<=0, p<=(g+1) mod N, state IDLE.
  - The loaded byte drains from the buffer normally.
  - The next grant may be issued while that byte is still pending.
- Watchdog:
  - Counter is $clog2(TIMEOUT+1) bits.
  - In LOCK it increments each cycle REQ[g]=0. It clears on any load and on entry to LOCK.
  - A high REQ[g] blocked by RDY=0 does not count.
  - When the counter equals TIMEOUT-1 with REQ[g]=0, the next edge does GNT<=0, p<=(g+1) mod N, ABORT=1 for one cycle, counter<=0, state IDLE.
  - The buffered byte is still sent.
- Simultaneous events:
  - Watchdog expiry and a load cannot coincide, because load needs REQ[g]=1.
  - Non-owner REQ is ignored during LOCK; no ACK to non-owners ever.
  - ACK is at most one-hot.
- N=1: p stays 0. The grant is re-issued 1 cycle after each release.
- Requester contract: after ACK it presents its next byte, or drops REQ, on the following cycle. DATA/LAST are sampled only when ACK is high.

Test Plan:
1. N=4, RDY=1. Lane 0 REQ with bytes 'H','i','!' (LAST on '!') -> GNT=0001 one cycle after REQ; ACK[0] on 3 consecutive cycles; OUT=48h,69h,21h on the following 3 cycles with OE=1; GNT=0 after the '!' load; OE=0 after '!' transfers.
2. REQ=1111 held, every byte LAST=1 -> grant sequence 0,1,2,3,0,1; exactly one byte per grant; no lane granted twice before all others.
3. Lane 1 mid-message, OE=1 with OUT=41h, RDY=0 for 5 cycles -> OUT stays 41h, ACK=0, ABORT never pulses (TIMEOUT=8); on RDY=1 transfers resume, one byte/cycle.
4. Lane 2 owns a 4-byte message; lane 0 raises REQ at byte 2 -> lane 0 receives no ACK until lane 2's LAST is taken; then p=3; with REQ[3]=0, lane 0 is granted the next cycle.
5. TIMEOUT=8. Lane 3 sends 1 non-LAST byte then drops REQ -> ABORT pulses once, exactly 8 cycles after that load; GNT=0; waiting lane 1 is granted on the following cycle; the already-loaded byte is still transferred.
6. RST_ low asynchronously while OE=1 and GNT=0100 -> OE, GNT, ACK go 0 without a clock edge; after RST_ high with REQ=1111, lane 0 is granted first.
